complex_operand_packer: RTL and testbench

Upstream feeder for the complex divider. Accepts a 64-bit IEEE-754 double stream one beat at a time: a, b, c, d for (a+jb)/(c+jd). Assembles each group of four beats into an operand bundle and flags divide-by-zero (c = d = ±0). Buffers up to DEPTH bundles and presents them to the divider's operands/in_valid/in_ready handshake.

---
 rtl/cplx_pkg.sv | 27 ++
 rtl/complex_operand_packer_bundle_fifo.sv | 66 ++++++
 rtl/complex_operand_packer.sv | 108 ++++++++++
 tb/tb_complex_operand_packer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared definitions for the complex divider operand path.
//   WIDTH          - bit width of one IEEE-754 double operand
//   NUM_OPERANDS   - beats per bundle (a, b, c, d)
//   OP_*           - operand positions inside a bundle
//   cplx_bundle_t  - assembled operands plus divide-by-zero flag
//   is_signed_zero - true for +0.0 / -0.0 (denormals are not zero)
package cplx_pkg;

  localparam int WIDTH        = 64;
  localparam int NUM_OPERANDS = 4;

  localparam int OP_A_RE = 0;
  localparam int OP_A_IM = 1;
  localparam int OP_B_RE = 2;
  localparam int OP_B_IM = 3;

  typedef struct packed {
    logic [NUM_OPERANDS-1:0][WIDTH-1:0] ops;
    logic                               dbz;
  } cplx_bundle_t;

  // Sign bit is ignored; any nonzero exponent/mantissa bit means nonzero.
  function automatic logic is_signed_zero(input logic [WIDTH-1:0] x);
    return (x[WIDTH-2:0] == '0);
  endfunction

endpackage

// File: rtl/complex_operand_packer_bundle_fifo.sv
// Synchronous FIFO of operand bundles feeding the complex divider.
// Ports:
//   clk_i, rst_ni (sync, active low), flush_i (sync clear)
//   push_i / data_i      - write side
//   pop_i  / data_o      - read side, data_o is the head (zero when empty)
//   full_o, empty_o, count_o (0..DEPTH)
module bundle_fifo
  import cplx_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  cplx_bundle_t data_i,
  input  logic         pop_i,
  output cplx_bundle_t data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  cplx_bundle_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  // A push while full is only legal if the head leaves on the same edge.
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Empty FIFO presents zeros so the outputs are clean after reset/flush.
  assign data_o = empty_o ? '0 : r_mem[r_rd];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; visibility is governed by the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && w_do_push) r_mem[r_wr] <= data_i;
  end

endmodule

// File: rtl/complex_operand_packer.sv
// Collects a, b, c, d double beats into bundles for the complex divider,
// flags c = d = +/-0, drops malformed bundles and queues complete ones.
// Ports:
//   clk_i, rst_ni (sync, active low), flush_i (sync clear)
//   beat_valid_i / beat_ready_o / beat_data_i / beat_last_i - beat input
//   out_valid_o / out_ready_i / operands_o / div_by_zero_o  - divider side
//   frame_err_o - one-cycle pulse when a malformed bundle is dropped
//   busy_o      - partial bundle held or FIFO occupied
//
// Assembly states (held in r_idx):
//   state        | meaning
//   COLLECT 0..2 | waiting for beat idx; beat stored in slot idx
//   COLLECT 3    | waiting for d; must carry last, pushes whole bundle
module complex_operand_packer #(
  parameter int WIDTH        = cplx_pkg::WIDTH,
  parameter int NUM_OPERANDS = cplx_pkg::NUM_OPERANDS,
  parameter int DEPTH        = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 beat_valid_i,
  output logic                                 beat_ready_o,
  input  logic [WIDTH-1:0]                     beat_data_i,
  input  logic                                 beat_last_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [NUM_OPERANDS-1:0][WIDTH-1:0]   operands_o,
  output logic                                 div_by_zero_o,
  output logic                                 frame_err_o,
  output logic                                 busy_o
);

  import cplx_pkg::*;

  localparam int IW   = $clog2(NUM_OPERANDS);
  localparam int LAST = NUM_OPERANDS - 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [IW-1:0]                     r_idx;
  logic [NUM_OPERANDS-2:0][WIDTH-1:0] r_slots;
  logic                              r_frame_err;

  logic          w_is_last_slot;
  logic          w_accept;
  logic          w_push;
  logic          w_frame_bad;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  cplx_bundle_t  w_bundle;
  cplx_bundle_t  w_head;

  assign w_is_last_slot = (r_idx == IW'(LAST));

  // Stall only the closing beat when the queue is full; earlier beats can
  // still land in the assembly slots. No path from out_ready_i.
  assign beat_ready_o = !(w_is_last_slot && w_full) && !flush_i && rst_ni;

  assign w_accept    = beat_valid_i && beat_ready_o;
  assign w_push      = w_accept && w_is_last_slot && beat_last_i;
  assign w_frame_bad = w_accept && (beat_last_i != w_is_last_slot);

  // The closing beat goes straight into the FIFO rather than a slot.
  assign w_bundle.ops = {beat_data_i, r_slots};
  assign w_bundle.dbz = is_signed_zero(r_slots[OP_B_RE]) && is_signed_zero(beat_data_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_idx       <= '0;
      r_slots     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_accept) begin
        if (w_is_last_slot || beat_last_i) begin
          r_idx <= '0;
        end else begin
          r_slots[r_idx] <= beat_data_i;
          r_idx          <= r_idx + 1'b1;
        end
      end
    end
  end

  assign w_pop = out_valid_o && out_ready_i;

  bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .data_i  (w_bundle),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign out_valid_o   = !w_empty;
  assign operands_o    = w_head.ops;
  assign div_by_zero_o = w_head.dbz;
  assign frame_err_o   = r_frame_err;
  assign busy_o        = (r_idx != '0) || (w_count != '0);

endmodule

// File: tb/tb_complex_operand_packer.sv
module tb_complex_operand_packer;

  localparam int DEPTH = 2;
  localparam logic [63:0] MAG = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [255:0] ops;
    logic         dbz;
  } bundle_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              beat_valid;
  logic              beat_ready_o;
  logic [63:0]       beat_data;
  logic              beat_last;
  logic              out_valid_o;
  logic              out_ready;
  logic [3:0][63:0]  operands_o;
  logic              div_by_zero_o;
  logic              frame_err_o;
  logic              busy_o;

  complex_operand_packer #(.WIDTH(64), .NUM_OPERANDS(4), .DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .beat_valid_i  (beat_valid),
    .beat_ready_o  (beat_ready_o),
    .beat_data_i   (beat_data),
    .beat_last_i   (beat_last),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready),
    .operands_o    (operands_o),
    .div_by_zero_o (div_by_zero_o),
    .frame_err_o   (frame_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_vectors   = 0;
  int miscompares = 0;

  // Reference model: queued bundles and the beats of the bundle in progress.
  bundle_t     exp_q[$];
  logic [63:0] part_q[$];
  logic        exp_fe   = 1'b0;
  logic        mon_en   = 1'b0;
  logic        acc_flag = 1'b0;
  logic        exp_ready;
  bundle_t     nb;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs checked and model advanced at the falling edge; inputs are
  // stable here and are what the next rising edge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = rst_n && !flush && !(part_q.size() == 3 && exp_q.size() == DEPTH);
      chk1("beat_ready", beat_ready_o, exp_ready);
      chk1("out_valid", out_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk256("operands", operands_o, exp_q[0].ops);
        chk1("div_by_zero", div_by_zero_o, exp_q[0].dbz);
      end
      chk1("busy", busy_o, (part_q.size() != 0) || (exp_q.size() != 0));
      chk1("frame_err", frame_err_o, exp_fe);
      acc_flag = beat_valid && beat_ready_o;

      if (!rst_n || flush) begin
        exp_q.delete();
        part_q.delete();
        exp_fe = 1'b0;
      end else begin
        exp_fe = 1'b0;
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (beat_valid && exp_ready) begin
          if (part_q.size() == 3) begin
            if (beat_last) begin
              nb.ops = {beat_data, part_q[2], part_q[1], part_q[0]};
              nb.dbz = ((part_q[2] & MAG) == 64'd0) && ((beat_data & MAG) == 64'd0);
              exp_q.push_back(nb);
            end else begin
              exp_fe = 1'b1;
            end
            part_q.delete();
          end else if (beat_last) begin
            exp_fe = 1'b1;
            part_q.delete();
          end else begin
            part_q.push_back(beat_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic l);
    beat_valid = 1'b1;
    beat_data  = d;
    beat_last  = l;
  endtask

  task automatic wait_accept(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (cycles > 3) out_ready = 1'b1;
    end while (!acc_flag && cycles < 200);
    if (!acc_flag) begin
      miscompares++;
      $display("FAIL accept_timeout observed=no-accept required=accept within 200 cycles");
    end
    beat_valid = 1'b0;
    beat_last  = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int c;
    drive_beat(d, l);
    wait_accept(c);
  endtask

  task automatic send_bundle(input logic [63:0] a, b, c, d);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, 1'b1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  function automatic logic [63:0] rnd_dbl();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] rnd_cd();
    case ($urandom_range(0, 5))
      0:       return 64'h0000_0000_0000_0000;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'h0000_0000_0000_0001;
      default: return rnd_dbl();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    rst_n = 1'b0; flush = 1'b0; beat_valid = 1'b0; beat_data = '0;
    beat_last = 1'b0; out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    chk1("reset_ready_low", beat_ready_o, 1'b0);
    repeat (2) tick();
    chk1("reset_out_valid", out_valid_o, 1'b0);
    chk256("reset_operands", operands_o, 256'd0);
    chk1("reset_dbz", div_by_zero_o, 1'b0);
    chk1("reset_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic bundle, then a flagged bundle (-0, +0 for c, d).
    send_bundle(64'h401C000000000000, 64'h4000000000000000,
                64'h3FF0000000000000, 64'h4000000000000000);
    chk1("latency_valid", out_valid_o, 1'b1);
    tick();
    send_bundle(64'h4014000000000000, 64'hC008000000000000,
                64'h8000000000000000, 64'h0000000000000000);
    chk1("dbz_flag", div_by_zero_o, 1'b1);
    repeat (3) tick();

    // Back-pressure: third bundle's closing beat must stall.
    out_ready = 1'b0;
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_dbl(), rnd_dbl());
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_dbl(), rnd_dbl());
    send_beat(rnd_dbl(), 1'b0);
    send_beat(rnd_dbl(), 1'b0);
    send_beat(rnd_dbl(), 1'b0);
    drive_beat(rnd_dbl(), 1'b1);
    repeat (4) tick();
    chk1("stall_ready", beat_ready_o, 1'b0);
    out_ready = 1'b1;
    wait_accept(c);
    repeat (6) tick();

    // Early last on beat 2, then a clean bundle.
    send_beat(rnd_dbl(), 1'b0);
    send_beat(rnd_dbl(), 1'b1);
    chk1("frame_err_pulse", frame_err_o, 1'b1);
    tick();
    chk1("frame_err_once", frame_err_o, 1'b0);
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_cd(), rnd_cd());
    repeat (3) tick();

    // Flush mid-bundle, then flush with queued bundles.
    send_beat(rnd_dbl(), 1'b0);
    send_beat(rnd_dbl(), 1'b0);
    pulse_flush();
    chk1("flush_busy", busy_o, 1'b0);
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_cd(), rnd_cd());
    repeat (3) tick();
    out_ready = 1'b0;
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_dbl(), rnd_dbl());
    send_bundle(rnd_dbl(), rnd_dbl(), rnd_dbl(), rnd_dbl());
    pulse_flush();
    chk1("flush_out_valid", out_valid_o, 1'b0);
    out_ready = 1'b1;
    tick();

    // Randomized bundles with random back-pressure and malformed framing.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(1, 4);
        for (int j = 1; j <= k; j++) begin
          out_ready = 1'($urandom_range(0, 1));
          send_beat(rnd_dbl(), (j == k) && (k < 4));
        end
      end else begin
        for (int j = 1; j <= 4; j++) begin
          out_ready = 1'($urandom_range(0, 1));
          send_beat((j > 2) ? rnd_cd() : rnd_dbl(), j == 4);
        end
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();

    // Back-to-back stream: every beat accepted on its first edge.
    for (int i = 0; i < 6; i++) begin
      for (int j = 1; j <= 4; j++) begin
        drive_beat((j > 2) ? rnd_cd() : rnd_dbl(), j == 4);
        wait_accept(c);
        chk1("stream_no_stall", c == 1, 1'b1);
      end
    end

    repeat (4) tick();
    chk1("drained_busy", busy_o, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
    $finish;
  end

endmodule
